add_sequencer: RTL
==================

# add_sequencer

Upstream control stage for the registered 16-bit adder datapath (`system`). It accepts operand pairs over a valid/ready stream and drives the adder's `d_a`/`d_b`/`cin` and `en_a`/`en_b`/`en_result` strobes in the required order. It then captures `result`/`cout` and presents them on a valid/ready output stream. It also checks every captured sum against an internally computed reference and counts completed operations.

## Interface
- `WIDTH`, 16, operand/result width; must match the adder.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  operand pair present.
- `in_ready`  out  1  block can accept an operand pair.
- `in_a`  in  WIDTH  operand A.
- `in_b`  in  WIDTH  operand B.
- `in_cin`  in  1  carry-in.
- `d_a`  out  WIDTH  to adder A input.
- `d_b`  out  WIDTH  to adder B input.
- `cin`  out  1  to adder carry-in.
- `en_a`  out  1  adder A-register load strobe.
- `en_b`  out  1  adder B-register load strobe.
- `en_result`  out  1  adder result-register load strobe.
- `result`  in  WIDTH  from adder result register.
- `cout`  in  1  from adder carry-out.
- `out_valid`  out  1  captured sum available.
- `out_ready`  in  1  consumer accepts the sum.
- `out_sum`  out  WIDTH  captured sum.
- `out_cout`  out  1  captured carry-out.
- `err`  out  1  sticky mismatch flag.
- `op_count`  out  16  completed-operation counter.

## Operation
- FSM states: IDLE, LOAD, EXEC, CAPT, OUT. Moore outputs are decoded from the state register.
- IDLE: `in_ready`=1.
  - On `in_valid && in_ready`, latch `in_a`, `in_b`, `in_cin` into the hold registers that drive `d_a`, `d_b`, `cin`.
  - Also latch the expected value `{1'b0,in_a}+{1'b0,in_b}+in_cin`, which is WIDTH+1 bits wide; the MSB is the expected carry.
  - Go to LOAD.
- LOAD: `en_a`=`en_b`=1. Go to EXEC.
- EXEC: `en_result`=1. Go to CAPT.
- CAPT:
  - Register `result` into `out_sum` and `cout` into `out_cout`.
  - If `{cout,result}` differs from the expected value, set `err`.
  - Go to OUT.
- OUT:
  - `out_valid`=1. `out_sum` and `out_cout` are held stable.
  - On `out_ready`, increment `op_count` and go to IDLE.
- `in_ready`=0 in every state except IDLE. `in_valid` outside IDLE is ignored and not consumed.
- Each strobe is high for exactly one cycle per operation and 0 in all other states.
- `d_a`, `d_b`, `cin` change only on acceptance and hold their value between operations.
- Arithmetic is modulo 2^WIDTH with carry reported separately. `op_count` wraps from 65535 to 0.
- `err` is cleared only by `rst`.

## Timing
- Reset values: all outputs 0, including `in_ready`. `in_ready` rises combinationally from IDLE once `rst` deasserts.
- Reset clears hold registers, the expected value, `out_sum`, `out_cout`, `err`, `op_count`, and puts the FSM in IDLE.
- Reset asserted mid-operation (any state) forces the above immediately. The adder's internal registers are not this block's responsibility.
- Cycle timing, with the accepting edge as E0:
  - LOAD is cycle 1. The adder registers A/B at E1.
  - EXEC is cycle 2. The adder registers its result at E2.
  - CAPT is cycle 3. The sum is captured at E3.
  - `out_valid` is high from E3.
- Latency from acceptance to `out_valid` is 3 cycles.
- With `out_ready` held at 1, the output handshake occurs at E4 and the next acceptance at E5. Peak throughput is one operation per 5 cycles.
- Backpressure: OUT persists while `out_ready`=0, with no limit.

## Structure
- Shared package `add_seq_pkg`:
  - state enum typedef `add_seq_state_t` (IDLE, LOAD, EXEC, CAPT, OUT);
  - `ADD_WIDTH_DEFAULT` = 16, also used by the adder.
- Flat implementation with no sub-module. The FSM, hold registers, checker and counter live together.
- The integration top instantiates `add_sequencer` together with `system`. Its active-low `rstn` is driven by `~rst`.

## Test plan
- Accept 100+50, `cin`=0, with `out_ready`=1:
  - `en_a`/`en_b` high only in cycle 1 and `en_result` only in cycle 2;
  - `out_valid` at E3 with `out_sum`=150, `out_cout`=0, `err`=0;
  - `op_count`=1.
- 65535+1, `cin`=0 → `out_sum`=0, `out_cout`=1. Then 65535+65535, `cin`=1 → `out_sum`=65535, `out_cout`=1. `err` stays 0.
- Backpressure:
  - hold `out_ready`=0 for 4 cycles in OUT;
  - `out_valid`/`out_sum` must stay stable and `in_ready`=0;
  - a pending `in_valid` must not be accepted until after the output handshake.
- Fault injection: bench drives `result` = correct+1 for 200+50 → `err`=1 after E3. `err` remains 1 through a following correct op (10+20 → 30).
- Reset pulse during EXEC:
  - all outputs go to 0 asynchronously and `op_count` reads 0;
  - after release `in_ready`=1;
  - a new op 7+8 then returns 15.
- `op_count` wrap: force `op_count` to 65535 at start of test (hierarchical deposit), run one op → `op_count`=0.

Source files
------------

// File: rtl/add_seq_pkg.sv
// add_seq_pkg: definitions shared by the add sequencer and the registered adder datapath.
//   ADD_WIDTH_DEFAULT - operand/result width used by both the sequencer and the adder
//   add_seq_state_t   - sequencer FSM state encoding
package add_seq_pkg;

   localparam int unsigned ADD_WIDTH_DEFAULT = 16;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StExec,
      StCapt,
      StOut
   } add_seq_state_t;

endpackage

// File: rtl/add_sequencer.sv
// add_sequencer: control stage in front of the registered adder datapath.
// Accepts an operand pair, strobes the adder's A/B registers and then its result register,
// captures result/cout, and offers them on a valid/ready output stream. Each captured sum is
// compared with a locally computed reference, and completed operations are counted.
//   clk, rst                     - clock, asynchronous active-high reset
//   in_valid/in_ready            - operand stream handshake
//   in_a, in_b, in_cin           - operands and carry-in
//   d_a, d_b, cin                - held operands driven to the adder
//   en_a, en_b, en_result        - one-cycle adder load strobes
//   result, cout                 - adder outputs
//   out_valid/out_ready          - result stream handshake
//   out_sum, out_cout            - captured sum and carry
//   err                          - sticky reference mismatch flag
//   op_count                     - completed-operation counter (wraps)
module add_sequencer
   import add_seq_pkg::*;
#(
   parameter int unsigned WIDTH = ADD_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   output logic [WIDTH-1:0] d_a,
   output logic [WIDTH-1:0] d_b,
   output logic             cin,
   output logic             en_a,
   output logic             en_b,
   output logic             en_result,
   input  logic [WIDTH-1:0] result,
   input  logic             cout,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             err,
   output logic [15:0]      op_count
);

   add_seq_state_t state_q, state_d;

   logic [WIDTH-1:0] a_q, b_q, sum_q;
   logic             cin_q, cout_q, err_q;
   logic [WIDTH:0]   exp_q;
   logic [15:0]      op_count_q;
   logic             accept, handshake;

   assign accept    = (state_q == StIdle) && in_valid;
   assign handshake = (state_q == StOut) && out_ready;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (in_valid) state_d = StLoad;
         StLoad:  state_d = StExec;
         StExec:  state_d = StCapt;
         StCapt:  state_d = StOut;
         StOut:   if (out_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         a_q        <= '0;
         b_q        <= '0;
         cin_q      <= 1'b0;
         exp_q      <= '0;
         sum_q      <= '0;
         cout_q     <= 1'b0;
         err_q      <= 1'b0;
         op_count_q <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            a_q   <= in_a;
            b_q   <= in_b;
            cin_q <= in_cin;
            exp_q <= {1'b0, in_a} + {1'b0, in_b} + {{WIDTH{1'b0}}, in_cin};
         end
         if (state_q == StCapt) begin
            sum_q  <= result;
            cout_q <= cout;
            if ({cout, result} != exp_q) err_q <= 1'b1;
         end
         if (handshake) op_count_q <= op_count_q + 16'd1;
      end
   end

   // Gate with rst so in_ready reads 0 while reset is held, rising only on release.
   assign in_ready  = (state_q == StIdle) && !rst;
   assign en_a      = (state_q == StLoad);
   assign en_b      = (state_q == StLoad);
   assign en_result = (state_q == StExec);
   assign out_valid = (state_q == StOut);
   assign d_a       = a_q;
   assign d_b       = b_q;
   assign cin       = cin_q;
   assign out_sum   = sum_q;
   assign out_cout  = cout_q;
   assign err       = err_q;
   assign op_count  = op_count_q;

endmodule
